md6_bram_mailbox: RTL
=====================

MD6_BRAM_MAILBOX -- requirements
Module: md6_bram_mailbox

Interface
REQ-001 SHALL provide parameter MBOX_BASE, default 14'h0000, BRAM word index of mailbox word 0.
REQ-002 SHALL provide parameter POLL_INTERVAL, default 16, idle cycles between doorbell reads (range 1..65535).
REQ-003 CLK  in  1  sole clock; all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 bramAddr  out  14  BRAM word index.
REQ-006 bramDout  out  32  BRAM write data.
REQ-007 bramWEN  out  4  byte write enables.
REQ-008 bramEN  out  1  BRAM enable.
REQ-009 bramDin  in  32  BRAM read data, valid one cycle after a read access.
REQ-010 cmd_valid  out  1  command offered to MD6 engine.
REQ-011 cmd_ready  in  1  engine accepts command.
REQ-012 cmd_src  out  32  PLB source address.
REQ-013 cmd_dst  out  32  PLB destination address.
REQ-014 cmd_count  out  16  number of 64-bit blocks.
REQ-015 done_valid  in  1  engine completion.
REQ-016 done_code  in  8  engine completion code (nonzero = engine error).
REQ-017 done_ready  out  1  completion accepted.

Function
REQ-018 Mailbox word offsets from MBOX_BASE SHALL be: 0 doorbell (bit0 GO), 1 src, 2 dst, 3 count[15:0], 4 checksum, 5 status.
REQ-019 States SHALL be IDLE, POLL, FETCH, CHECK, ISSUE, BUSY, WRSTAT, CLRDB.
REQ-020 IDLE SHALL count POLL_INTERVAL cycles, then enter POLL.
REQ-021 Read access SHALL drive bramEN=1, bramWEN=0, bramAddr in cycle N; data SHALL be sampled from bramDin in cycle N+1.
REQ-022 POLL SHALL read word 0; GO=0 returns to IDLE with timer restarted; GO=1 enters FETCH.
REQ-023 FETCH SHALL read words 1..3 (1..4 with checksum feature) on consecutive cycles, pipelined, one access per cycle.
REQ-024 CHECK SHALL enter WRSTAT with err=1 when count==0 (or checksum mismatches); otherwise enter ISSUE.
REQ-025 ISSUE SHALL hold cmd_valid=1 with stable cmd_src/cmd_dst/cmd_count until cmd_ready sampled high, then enter BUSY.
REQ-026 cmd_valid and cmd_ready both high in one cycle SHALL count as exactly one transfer; cmd_valid SHALL drop the next cycle.
REQ-027 BUSY SHALL assert done_ready=1 only in that state; done_valid&done_ready SHALL capture done_code and enter WRSTAT.
REQ-028 done_valid outside BUSY SHALL be ignored.
REQ-029 WRSTAT SHALL write word 5 = {16'h0, code[7:0], 6'b0, err, 1'b1}, bramWEN=4'hF, single cycle; err = (done_code!=0) or CHECK failure (code=0 on CHECK failure).
REQ-030 CLRDB SHALL write word 0 = 32'h0 with bramWEN=4'hF, then return to IDLE with timer restarted.
REQ-031 bramEN SHALL be 0 in every cycle without an access; bramDout SHALL be don't-care-free (0) on reads.
REQ-032 Address arithmetic SHALL be MBOX_BASE+offset modulo 2^14 (wrap at top of BRAM).

Reset
REQ-033 RST high SHALL force state IDLE, poll timer 0, bramEN=0, bramWEN=0, bramAddr=0, bramDout=0, cmd_valid=0, cmd_src/dst/count=0, done_ready=0, asynchronously.
REQ-034 RST mid-operation SHALL abandon the command with no status write; doorbell left set is re-serviced after reset.

Configuration
REQ-035 With MD6_MAILBOX_CHECKSUM_EN defined, FETCH SHALL read word 4 and CHECK SHALL require word4 == src ^ dst ^ {16'h0,count}.
REQ-036 Without MD6_MAILBOX_CHECKSUM_EN, word 4 SHALL never be read and only the count==0 check SHALL apply.

Structure
REQ-037 Package md6_mailbox_pkg SHALL hold word-offset constants, state enum, status bit positions.
REQ-038 Poll counter SHALL be sub-module md6_poll_timer (load, tick, expire); all else inline.

Verification
REQ-039 Doorbell 0 for 100 cycles, POLL_INTERVAL=16 -> one word-0 read every 17 cycles, cmd_valid never high.
REQ-040 GO=1, src=32'h1000, dst=32'h2000, count=4, cmd_ready held low 10 cycles -> cmd_valid stable 10+ cycles, one transfer, no re-issue.
REQ-041 Engine returns done_code=8'h00 -> word5=32'h0000_0001 then word0=0, in consecutive cycles.
REQ-042 count=0 -> no cmd_valid; word5=32'h0000_0003; word0 cleared.
REQ-043 MD6_MAILBOX_CHECKSUM_EN, checksum off by 1 -> word5=32'h0000_0003, no cmd; correct checksum -> command issued.
REQ-044 RST asserted during BUSY -> all outputs at reset values same cycle; doorbell still 1 re-fetched after first poll interval.

Source files
------------

// File: rtl/md6_mailbox_pkg.sv
// MD6 BRAM mailbox shared definitions: word offsets, FSM states,
// status word layout and mailbox address helper.
package md6_mailbox_pkg;

  localparam int unsigned ADDR_W = 14;

  localparam logic [2:0] OFF_DB   = 3'd0;
  localparam logic [2:0] OFF_SRC  = 3'd1;
  localparam logic [2:0] OFF_DST  = 3'd2;
  localparam logic [2:0] OFF_CNT  = 3'd3;
  localparam logic [2:0] OFF_CSUM = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;

  localparam int unsigned ST_DONE_BIT = 0;
  localparam int unsigned ST_ERR_BIT  = 1;
  localparam int unsigned ST_CODE_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_BUSY,
    S_WRSTAT,
    S_CLRDB
  } state_e;

  // Mailbox word address, wrapping at the top of the BRAM
  function automatic logic [ADDR_W-1:0] mbox_addr(
    input logic [ADDR_W-1:0] base,
    input logic [2:0]        off
  );
    return base + {{(ADDR_W-3){1'b0}}, off};
  endfunction

  function automatic logic [31:0] status_word(
    input logic [7:0] code,
    input logic       err
  );
    logic [31:0] w;
    w = '0;
    w[ST_DONE_BIT] = 1'b1;
    w[ST_ERR_BIT] = err;
    w[ST_CODE_LSB +: 8] = code;
    return w;
  endfunction

endpackage

// File: rtl/md6_poll_timer.sv
// Doorbell poll interval counter: load restarts, tick advances,
// expire flags the last idle cycle of the interval.
module md6_poll_timer
  import md6_mailbox_pkg::*;
#(
  parameter int unsigned INTERVAL = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam logic [15:0] LAST = 16'(INTERVAL - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign expire_o = tick_i && (cnt_q == LAST);

  // Next count: restart on load or expiry, otherwise advance on tick
  always_comb begin
    cnt_d = cnt_q;
    if (load_i || expire_o) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/md6_bram_mailbox.sv
// BRAM mailbox poller feeding commands to the MD6 engine.
// Optional MD6_MAILBOX_CHECKSUM_EN adds a word-4 checksum check.
module md6_bram_mailbox
  import md6_mailbox_pkg::*;
#(
  parameter logic [13:0] MBOX_BASE     = 14'h0000,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [13:0] bramAddr,
  output logic [31:0] bramDout,
  output logic [3:0]  bramWEN,
  output logic        bramEN,
  input  logic [31:0] bramDin,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_src,
  output logic [31:0] cmd_dst,
  output logic [15:0] cmd_count,
  input  logic        done_valid,
  input  logic [7:0]  done_code,
  output logic        done_ready
);

`ifdef MD6_MAILBOX_CHECKSUM_EN
  localparam logic [2:0] FETCH_N = 3'd4;
`else
  localparam logic [2:0] FETCH_N = 3'd3;
`endif

  state_e      state_q, state_d;
  logic [2:0]  fidx_q, fidx_d;
  logic        rd_pend_q, rd_pend_d;
  logic [2:0]  rd_off_q, rd_off_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  code_q, code_d;
  logic        err_q, err_d;
`ifdef MD6_MAILBOX_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic tmr_load;
  logic tmr_tick;
  logic tmr_expire;
  logic go_seen;
  logic chk_fail;

  md6_poll_timer #(
    .INTERVAL(POLL_INTERVAL)
  ) u_timer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (tmr_load),
    .tick_i  (tmr_tick),
    .expire_o(tmr_expire)
  );

  // Doorbell data returns during the first idle cycle after a poll
  assign go_seen = rd_pend_q && (rd_off_q == OFF_DB) && bramDin[0];

`ifdef MD6_MAILBOX_CHECKSUM_EN
  assign chk_fail = (cnt_q == 16'h0) ||
                    (csum_q != (src_q ^ dst_q ^ {16'h0, cnt_q}));
`else
  assign chk_fail = (cnt_q == 16'h0);
`endif

  assign cmd_valid  = (state_q == S_ISSUE);
  assign done_ready = (state_q == S_BUSY);
  assign cmd_src    = src_q;
  assign cmd_dst    = dst_q;
  assign cmd_count  = cnt_q;
  assign rd_pend_d  = bramEN && (bramWEN == 4'h0);

  // Next state, BRAM access generation and mailbox word capture
  always_comb begin
    state_d  = state_q;
    fidx_d   = fidx_q;
    rd_off_d = OFF_DB;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    err_d    = err_q;
`ifdef MD6_MAILBOX_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    bramEN   = 1'b0;
    bramWEN  = 4'h0;
    bramAddr = 14'h0;
    bramDout = 32'h0;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;

    if (rd_pend_q) begin
      unique case (rd_off_q)
        OFF_SRC: src_d = bramDin;
        OFF_DST: dst_d = bramDin;
        OFF_CNT: cnt_d = bramDin[15:0];
`ifdef MD6_MAILBOX_CHECKSUM_EN
        OFF_CSUM: csum_d = bramDin;
`endif
        default: ;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (go_seen) begin
          fidx_d  = 3'd0;
          state_d = S_FETCH;
        end else begin
          tmr_tick = 1'b1;
          if (tmr_expire) begin
            state_d = S_POLL;
          end
        end
      end
      S_POLL: begin
        bramEN   = 1'b1;
        bramAddr = mbox_addr(MBOX_BASE, OFF_DB);
        rd_off_d = OFF_DB;
        tmr_load = 1'b1;
        state_d  = S_IDLE;
      end
      S_FETCH: begin
        if (fidx_q < FETCH_N) begin
          rd_off_d = OFF_SRC + fidx_q;
          bramEN   = 1'b1;
          bramAddr = mbox_addr(MBOX_BASE, rd_off_d);
          fidx_d   = fidx_q + 3'd1;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        code_d = 8'h00;
        if (chk_fail) begin
          err_d   = 1'b1;
          state_d = S_WRSTAT;
        end else begin
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (done_valid) begin
          code_d  = done_code;
          err_d   = |done_code;
          state_d = S_WRSTAT;
        end
      end
      S_WRSTAT: begin
        bramEN   = 1'b1;
        bramWEN  = 4'hF;
        bramAddr = mbox_addr(MBOX_BASE, OFF_STAT);
        bramDout = status_word(code_q, err_q);
        state_d  = S_CLRDB;
      end
      S_CLRDB: begin
        bramEN   = 1'b1;
        bramWEN  = 4'hF;
        bramAddr = mbox_addr(MBOX_BASE, OFF_DB);
        tmr_load = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      fidx_q    <= 3'd0;
      rd_pend_q <= 1'b0;
      rd_off_q  <= OFF_DB;
      src_q     <= 32'h0;
      dst_q     <= 32'h0;
      cnt_q     <= 16'h0;
      code_q    <= 8'h0;
      err_q     <= 1'b0;
`ifdef MD6_MAILBOX_CHECKSUM_EN
      csum_q    <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      fidx_q    <= fidx_d;
      rd_pend_q <= rd_pend_d;
      rd_off_q  <= rd_off_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      err_q     <= err_d;
`ifdef MD6_MAILBOX_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule
